// File: rtl/sram_core_bist_if.sv
// Functional SRAM access bus: one strobe-qualified read or write per cycle,
// registered read data and a one-cycle out-of-range error pulse.
interface sram_core_bist_if #(
  parameter int AW = 16,
  parameter int DW = 23
);
  logic          sram_cs;
  logic          sram_wr;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata;
  logic          oob_err;

  modport master (
    output sram_cs, sram_wr, sram_addr, sram_wdata,
    input  sram_rdata, oob_err
  );

  modport slave (
    input  sram_cs, sram_wr, sram_addr, sram_wdata,
    output sram_rdata, oob_err
  );
endinterface

// File: rtl/sram_core_bist.sv
// Single-port DEPTH x DW SRAM with a March-style built-in self test
// (W0 up, R0W1 up, R1W0 down, R0 up). Functional accesses are locked out
// while the BIST owns the array. fi_en clears bit 0 of every array write so
// the BIST miscompare path can be exercised on purpose.
module sram_core_bist #(
  parameter int AW    = 16,
  parameter int DW    = 23,
  parameter int DEPTH = 4096
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  sram_core_bist_if.slave      bus,
  input  logic                 bist_start,
  input  logic                 fi_en,
  output logic                 bist_busy,
  output logic                 bist_done,
  output logic                 bist_fail,
  output logic [AW-1:0]        fail_addr
);

  localparam int            IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH == 2**AW still compares correctly.
  localparam logic [AW:0]   DEPTH_X   = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    W0_UP,
    R0W1_UP,
    R1W0_DN,
    R0_UP,
    CHK,
    DONE
  } bist_state_e;

  bist_state_e   state;
  logic [AW-1:0] bist_addr;
  logic          phase;        // 0 = read slot, 1 = write slot in R0W1/R1W0

  // Pending comparison for the BIST read issued in the previous cycle.
  logic          chk_valid_q;
  logic          chk_ones_q;
  logic [AW-1:0] chk_addr_q;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_q;

  logic          in_range;
  logic          func_we;
  logic          func_re;
  logic          bist_we;
  logic          bist_re;
  logic          bist_exp_ones;
  logic [DW-1:0] bist_wd;
  logic          arr_we;
  logic [DW-1:0] arr_wd;
  logic [IW-1:0] arr_idx;

  assign in_range = ({1'b0, bus.sram_addr} < DEPTH_X);
  assign func_we  = bus.sram_cs &  bus.sram_wr & in_range & ~bist_busy;
  assign func_re  = bus.sram_cs & ~bus.sram_wr & ~bist_busy;

  // BIST array operation for the current state/phase.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one
    // unassigned and infers a latch.
    bist_we       = 1'b0;
    bist_re       = 1'b0;
    bist_wd       = '0;
    bist_exp_ones = 1'b0;
    case (state)
      W0_UP:   bist_we = 1'b1;
      R0W1_UP: begin
        if (!phase) begin
          bist_re = 1'b1;
        end else begin
          bist_we = 1'b1;
          bist_wd = '1;
        end
      end
      R1W0_DN: begin
        if (!phase) begin
          bist_re       = 1'b1;
          bist_exp_ones = 1'b1;
        end else begin
          bist_we = 1'b1;
        end
      end
      R0_UP:   bist_re = 1'b1;
      default: ;
    endcase
  end

  // Array port mux: the BIST owns the single port while busy.
  always_comb begin
    arr_idx = bist_busy ? bist_addr[IW-1:0] : bus.sram_addr[IW-1:0];
    arr_we  = bist_busy ? bist_we : func_we;
    arr_wd  = bist_busy ? bist_wd : bus.sram_wdata;
    if (fi_en) arr_wd[0] = 1'b0;
  end

  // Storage array plus the BIST read register.
  always_ff @(posedge PCLK) begin
    // NOTE: the array and its raw read register are deliberately not reset;
    // contents must survive PRESETn and a reset would prevent RAM mapping.
    if (arr_we) mem[arr_idx] <= arr_wd;
    rd_q <= mem[arr_idx];
  end

  // Functional read data and out-of-range pulse.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      bus.sram_rdata <= '0;
      bus.oob_err    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      bus.oob_err <= bus.sram_cs & ~bist_busy & ~in_range;
      if (func_re) bus.sram_rdata <= in_range ? mem[arr_idx] : '0;
    end
  end

  // BIST sequencer, compare stage and sticky status.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state       <= IDLE;
      bist_addr   <= '0;
      phase       <= 1'b0;
      bist_busy   <= 1'b0;
      bist_done   <= 1'b0;
      bist_fail   <= 1'b0;
      fail_addr   <= '0;
      chk_valid_q <= 1'b0;
      chk_ones_q  <= 1'b0;
      chk_addr_q  <= '0;
    end else begin
      chk_valid_q <= bist_re;
      chk_ones_q  <= bist_exp_ones;
      chk_addr_q  <= bist_addr;

      if (chk_valid_q && (rd_q != {DW{chk_ones_q}})) begin
        bist_fail <= 1'b1;
        if (!bist_fail) fail_addr <= chk_addr_q;
      end

      case (state)
        IDLE: begin
          if (bist_start) begin
            state     <= W0_UP;
            bist_busy <= 1'b1;
            bist_done <= 1'b0;
            bist_fail <= 1'b0;
            fail_addr <= '0;
            bist_addr <= '0;
            phase     <= 1'b0;
          end
        end
        W0_UP: begin
          if (bist_addr == LAST_ADDR) begin
            state     <= R0W1_UP;
            bist_addr <= '0;
          end else begin
            bist_addr <= bist_addr + 1'b1;
          end
        end
        R0W1_UP: begin
          phase <= ~phase;
          if (phase) begin
            if (bist_addr == LAST_ADDR) state <= R1W0_DN;
            else                        bist_addr <= bist_addr + 1'b1;
          end
        end
        R1W0_DN: begin
          phase <= ~phase;
          if (phase) begin
            if (bist_addr == '0) state <= R0_UP;
            else                 bist_addr <= bist_addr - 1'b1;
          end
        end
        R0_UP: begin
          if (bist_addr == LAST_ADDR) begin
            state     <= CHK;
            bist_addr <= '0;
          end else begin
            bist_addr <= bist_addr + 1'b1;
          end
        end
        CHK: begin
          state     <= DONE;
          bist_busy <= 1'b0;
          bist_done <= 1'b1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
